equiv_stream_miter: RTL and testbench
=====================================

Name: equiv_stream_miter

Overview:
- Parametrised successor to the lockstep identity miter in the fuzz/equivalence flow.
- Compares output streams of two candidate implementations (e.g. original vs. synthesised netlist) that may have different, unknown latencies.
- Each side pushes valid-qualified samples into its own alignment FIFO. Head samples are popped pairwise and compared under a don't-care mask.
- First-mismatch context, counters and sticky error flags are reported for the formal/sim harness to assert on.

Parameters:
- WIDTH, 91, sample width of y_1/y_2.
- DEPTH, 8, per-side alignment FIFO depth; power of two, >=2.
- CNT_W, 16, width of compare and mismatch counters (saturating).
- WARMUP, 0, number of initial aligned pairs excluded from checking after reset/clear.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous: flush FIFOs, zero counters and flags, restart warmup.
- valid_1  in  1  y_1 sample present this cycle.
- y_1  in  WIDTH  sample from implementation 1.
- valid_2  in  1  y_2 sample present this cycle.
- y_2  in  WIDTH  sample from implementation 2.
- mask  in  WIDTH  1 = bit compared, 0 = don't care; sampled at compare time.
- cmp_valid  out  1  pulse: a pair was compared (post-warmup) this cycle.
- mismatch  out  1  pulse with cmp_valid when masked pair differs.
- mismatch_sticky  out  1  set on first mismatch, held until clear/reset.
- overflow_sticky  out  1  set when a push hits a full FIFO.
- cmp_count  out  CNT_W  post-warmup pairs compared, saturating.
- mis_count  out  CNT_W  mismatching pairs, saturating.
- first_idx  out  CNT_W  cmp_count value at first mismatch.
- first_y1  out  WIDTH  y_1 of first mismatching pair.
- first_y2  out  WIDTH  y_2 of first mismatching pair.

Behaviour:
- Reset (rst_n low, async): FIFOs empty; all outputs 0; warmup counter = WARMUP; state WARM (or CHECK if WARMUP=0).
- Push: valid_x pushes y_x into FIFO_x the same edge. A push to a full FIFO is dropped and sets overflow_sticky. A pop and a push on the same edge with FIFO full is allowed (no overflow).
- Pop: when both FIFOs are non-empty at the start of a cycle, both heads pop on that edge. Pairing latency is 1 cycle minimum: a sample pushed at edge N can pop at edge N+1.
- Compare is registered. Outputs for a pair popped at edge N appear after edge N. diff = (head1 ^ head2) & mask.
- States:
  - WARM: pops decrement the warmup counter; no compare outputs. At 0, go to CHECK.
  - CHECK: each pop gives cmp_valid=1; mismatch = |diff.
    - mismatch=1: mis_count++. If mismatch_sticky was 0, capture first_idx = cmp_count (pre-increment value), first_y1, first_y2, and set mismatch_sticky.
    - cmp_count++ on every CHECK pop.
- Counters saturate at all-ones; they never wrap. first_* is captured only once.
- clear: has priority over push/pop in the same cycle; that cycle's inputs are discarded. Returns to the reset state except it is synchronous.
- A one-sided stream with the other side silent fills its FIFO, then overflow_sticky is set. No comparison happens.
- Reset asserted mid-stream discards all FIFO contents immediately.
- mask = 0 everywhere means every pair matches.

Decomposition:
- Shared package equiv_pkg: status-state enum (WARM, CHECK), saturating-increment function, default WIDTH/DEPTH constants shared with the miter harness.
- One sub-module: equiv_align_fifo (parametrised WIDTH/DEPTH sync FIFO; push/pop/full/empty; async active-low reset). Instantiated twice.

Test Plan:
- Equal streams, y_2 delayed 3 cycles vs y_1, 20 samples 0..19 -> cmp_count=20, mis_count=0, mismatch_sticky=0, overflow_sticky=0.
- Sample 5 differs in bit 0 (y_1=5, y_2=4), mask all-ones -> mismatch pulse once; first_idx=5, first_y1=5, first_y2=4, mis_count=1. A second mismatch at 9 leaves first_* unchanged and gives mis_count=2.
- Same bit-0 difference with mask bit 0 = 0 -> no mismatch, mis_count=0.
- DEPTH=8, valid_1 for 9 cycles, valid_2 held 0 -> overflow_sticky=1 after the 9th push, cmp_count=0.
- WARMUP=2, first two pairs differ, rest equal -> mismatch_sticky=0, cmp_count = total pairs - 2.
- rst_n pulsed low mid-stream with 4 samples buffered -> all outputs 0 asynchronously. After release, new equal streams compare from cmp_count=0.
- clear asserted with mismatch_sticky=1 -> flags and counters 0 next cycle.

Source files
------------

// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - shared types and helpers for the stream equivalence miter
package equiv_pkg;

    localparam int DEF_WIDTH = 91;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        WARM  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        return (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/equiv_align_fifo.sv
// rtl/equiv_align_fifo.sv - per-side alignment FIFO, head visible on dout
module equiv_align_fifo #(
    parameter int WIDTH = 91,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/equiv_stream_miter.sv
// rtl/equiv_stream_miter.sv - latency-tolerant masked comparison of two sample streams
module equiv_stream_miter
    import equiv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = 16,
    parameter int WARMUP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid_1,
    input  logic [WIDTH-1:0] y_1,
    input  logic             valid_2,
    input  logic [WIDTH-1:0] y_2,
    input  logic [WIDTH-1:0] mask,
    output logic             cmp_valid,
    output logic             mismatch,
    output logic             mismatch_sticky,
    output logic             overflow_sticky,
    output logic [CNT_W-1:0] cmp_count,
    output logic [CNT_W-1:0] mis_count,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_y1,
    output logic [WIDTH-1:0] first_y2
);
    localparam int          WW         = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP);
    localparam state_t      INIT_STATE = (WARMUP == 0) ? CHECK : WARM;

    logic [WIDTH-1:0] head_1, head_2;
    logic             full_1, full_2, empty_1, empty_2;
    logic             pop, check_pop, diff_any, ovf;
    state_t           state_q, state_d;
    logic [WW-1:0]    warm_q, warm_d;

    assign pop       = !empty_1 && !empty_2 && !clear;
    assign check_pop = pop && (state_q == CHECK);
    assign diff_any  = |((head_1 ^ head_2) & mask);
    assign ovf       = !clear && !pop && ((valid_1 && full_1) || (valid_2 && full_2));

    equiv_align_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .push(valid_1 && !clear), .din(y_1), .pop(pop),
        .dout(head_1), .full(full_1), .empty(empty_1)
    );

    equiv_align_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .push(valid_2 && !clear), .din(y_2), .pop(pop),
        .dout(head_2), .full(full_2), .empty(empty_2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_STATE;
            warm_q  <= WARM_INIT;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    // The pair that brings the warmup counter to zero is still excluded.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (clear) begin
            state_d = INIT_STATE;
            warm_d  = WARM_INIT;
        end else if (pop && (state_q == WARM)) begin
            warm_d = warm_q - WW'(1);
            if (warm_q <= WW'(1)) state_d = CHECK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid       <= 1'b0;
            mismatch        <= 1'b0;
            mismatch_sticky <= 1'b0;
            overflow_sticky <= 1'b0;
            cmp_count       <= '0;
            mis_count       <= '0;
            first_idx       <= '0;
            first_y1        <= '0;
            first_y2        <= '0;
        end else if (clear) begin
            cmp_valid       <= 1'b0;
            mismatch        <= 1'b0;
            mismatch_sticky <= 1'b0;
            overflow_sticky <= 1'b0;
            cmp_count       <= '0;
            mis_count       <= '0;
            first_idx       <= '0;
            first_y1        <= '0;
            first_y2        <= '0;
        end else begin
            cmp_valid <= check_pop;
            mismatch  <= check_pop && diff_any;
            if (ovf) overflow_sticky <= 1'b1;
            if (check_pop) begin
                cmp_count <= CNT_W'(sat_inc(64'(cmp_count), CNT_W));
                if (diff_any) begin
                    mis_count <= CNT_W'(sat_inc(64'(mis_count), CNT_W));
                    if (!mismatch_sticky) begin
                        mismatch_sticky <= 1'b1;
                        first_idx       <= cmp_count;
                        first_y1        <= head_1;
                        first_y2        <= head_2;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_equiv_stream_miter.sv
// tb/tb_equiv_stream_miter.sv - directed self-checking bench for equiv_stream_miter
module tb_equiv_stream_miter;
    localparam int W  = 91;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          valid_1, valid_2;
    logic [W-1:0]  y_1, y_2, mask;

    logic          cmp_valid, mismatch, mismatch_sticky, overflow_sticky;
    logic [CW-1:0] cmp_count, mis_count, first_idx;
    logic [W-1:0]  first_y1, first_y2;

    logic          w_cmp_valid, w_mismatch, w_mismatch_sticky, w_overflow_sticky;
    logic [CW-1:0] w_cmp_count, w_mis_count, w_first_idx;
    logic [W-1:0]  w_first_y1, w_first_y2;

    int checks = 0;
    int errors = 0;
    int mis_pulses = 0;
    logic [W-1:0] ones;

    always #5 clk = ~clk;

    equiv_stream_miter #(.WIDTH(W), .DEPTH(8), .CNT_W(CW), .WARMUP(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .valid_1(valid_1), .y_1(y_1), .valid_2(valid_2), .y_2(y_2), .mask(mask),
        .cmp_valid(cmp_valid), .mismatch(mismatch),
        .mismatch_sticky(mismatch_sticky), .overflow_sticky(overflow_sticky),
        .cmp_count(cmp_count), .mis_count(mis_count), .first_idx(first_idx),
        .first_y1(first_y1), .first_y2(first_y2)
    );

    equiv_stream_miter #(.WIDTH(W), .DEPTH(8), .CNT_W(CW), .WARMUP(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .valid_1(valid_1), .y_1(y_1), .valid_2(valid_2), .y_2(y_2), .mask(mask),
        .cmp_valid(w_cmp_valid), .mismatch(w_mismatch),
        .mismatch_sticky(w_mismatch_sticky), .overflow_sticky(w_overflow_sticky),
        .cmp_count(w_cmp_count), .mis_count(w_mis_count), .first_idx(w_first_idx),
        .first_y1(w_first_y1), .first_y2(w_first_y2)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v1, input logic [W-1:0] a, input logic v2, input logic [W-1:0] b);
        valid_1 = v1;
        y_1     = a;
        valid_2 = v2;
        y_2     = b;
        @(posedge clk);
        #1;
        if (mismatch) mis_pulses++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        clear = 1'b0;
        mis_pulses = 0;
    endtask

    // Side 2 lags by 'delay' cycles; samples bad_a/bad_b on side 2 have bit 0 flipped.
    task automatic run_stream(input int n, input int delay, input int bad_a, input int bad_b);
        for (int t = 0; t < n + delay + 3; t++) begin
            int s;
            logic [W-1:0] b;
            s = t - delay;
            b = W'(s);
            if (s == bad_a || s == bad_b) b = b ^ W'(1);
            step(t < n, W'(t), (s >= 0) && (s < n), b);
        end
    endtask

    initial begin
        ones    = '1;
        rst_n   = 1'b0;
        clear   = 1'b0;
        valid_1 = 1'b0;
        valid_2 = 1'b0;
        y_1     = '0;
        y_2     = '0;
        mask    = ones;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmp_valid", W'(cmp_valid), W'(0));
        chk("rst_sticky", W'(mismatch_sticky), W'(0));
        chk("rst_ovf", W'(overflow_sticky), W'(0));
        chk("rst_cmp_count", W'(cmp_count), W'(0));
        chk("rst_first_y1", first_y1, W'(0));
        rst_n = 1'b1;

        run_stream(20, 3, -1, -1);
        chk("eq_cmp_count", W'(cmp_count), W'(20));
        chk("eq_mis_count", W'(mis_count), W'(0));
        chk("eq_sticky", W'(mismatch_sticky), W'(0));
        chk("eq_ovf", W'(overflow_sticky), W'(0));

        do_clear();
        run_stream(20, 3, 5, 9);
        chk("mis_pulses", W'(mis_pulses), W'(2));
        chk("mis_count", W'(mis_count), W'(2));
        chk("mis_sticky", W'(mismatch_sticky), W'(1));
        chk("mis_first_idx", W'(first_idx), W'(5));
        chk("mis_first_y1", first_y1, W'(5));
        chk("mis_first_y2", first_y2, W'(4));
        chk("mis_cmp_count", W'(cmp_count), W'(20));

        clear = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        clear = 1'b0;
        chk("clr_sticky", W'(mismatch_sticky), W'(0));
        chk("clr_mis_count", W'(mis_count), W'(0));
        chk("clr_cmp_count", W'(cmp_count), W'(0));
        chk("clr_first_y1", first_y1, W'(0));

        mis_pulses = 0;
        mask = ones ^ W'(1);
        run_stream(20, 3, 5, 9);
        chk("mask_mis_count", W'(mis_count), W'(0));
        chk("mask_cmp_count", W'(cmp_count), W'(20));
        mask = '0;
        do_clear();
        run_stream(6, 0, 1, 2);
        chk("mask0_mis_count", W'(mis_count), W'(0));
        mask = ones;

        do_clear();
        for (int i = 0; i < 8; i++) step(1'b1, W'(i), 1'b0, '0);
        chk("ovf_after8", W'(overflow_sticky), W'(0));
        step(1'b1, W'(8), 1'b0, '0);
        chk("ovf_after9", W'(overflow_sticky), W'(1));
        repeat (2) step(1'b0, '0, 1'b0, '0);
        chk("ovf_cmp_count", W'(cmp_count), W'(0));

        do_clear();
        for (int i = 0; i < 8; i++) step(1'b1, W'(i), 1'b0, '0);
        step(1'b0, '0, 1'b1, W'(0));
        step(1'b1, W'(8), 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        chk("fullpop_ovf", W'(overflow_sticky), W'(0));
        chk("fullpop_cmp", W'(cmp_count), W'(1));
        chk("fullpop_mis", W'(mis_count), W'(0));

        do_clear();
        run_stream(10, 0, 0, 1);
        chk("warm_sticky", W'(w_mismatch_sticky), W'(0));
        chk("warm_cmp_count", W'(w_cmp_count), W'(8));
        chk("warm_mis_count", W'(w_mis_count), W'(0));

        do_clear();
        run_stream(3, 0, 1, -1);
        chk("pre_rst_sticky", W'(mismatch_sticky), W'(1));
        for (int i = 0; i < 4; i++) step(1'b1, W'(100 + i), 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmp_count", W'(cmp_count), W'(0));
        chk("arst_mis_count", W'(mis_count), W'(0));
        chk("arst_sticky", W'(mismatch_sticky), W'(0));
        chk("arst_first_idx", W'(first_idx), W'(0));
        chk("arst_first_y1", first_y1, W'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_stream(3, 0, -1, -1);
        chk("post_rst_cmp", W'(cmp_count), W'(3));
        chk("post_rst_mis", W'(mis_count), W'(0));
        chk("post_rst_ovf", W'(overflow_sticky), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
